// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle logic/shift ops
// plus iterative shift-add multiply and restoring divide, one bit per cycle.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] hi, lo, b;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    logic             multi;
    logic [WIDTH-1:0] sum, dif, alu_res;
    logic [SHW-1:0]   sh;
    logic             alu_ovf;

    assign multi = (alu_op >= 4'd11) && (alu_op <= 4'd14);

    always_comb begin
        sum     = op1 + op2;
        dif     = op1 - op2;
        sh      = op2[SHW-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            4'd0, 4'd7: begin
                alu_res = sum;
                alu_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            4'd1: begin
                alu_res = dif;
                alu_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (dif[WIDTH-1] != op1[WIDTH-1]);
            end
            4'd2:    alu_res = op1 | op2;
            4'd3:    alu_res = op1 ^ op2;
            4'd4:    alu_res = op1 & op2;
            4'd5:    alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            4'd8:    alu_res = op1 << sh;
            4'd9:    alu_res = op1 >> sh;
            4'd10:   alu_res = $signed(op1) >>> sh;
            4'd15:   alu_res = ~(op1 | op2);
            default: alu_res = '0;
        endcase
    end

    // {hi,lo} is the product register for mul (lo = multiplier, shifted out LSB first)
    // and {remainder,quotient} for div (lo = dividend shifted out MSB first).
    logic [WIDTH:0]   madd, dsh, ddif;
    logic [WIDTH-1:0] hi_n, lo_n;

    always_comb begin
        madd = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        dsh  = {hi, lo[WIDTH-1]};
        ddif = dsh - {1'b0, b};
        if (op_r == 4'd11 || op_r == 4'd12) begin
            hi_n = madd[WIDTH:1];
            lo_n = {madd[0], lo[WIDTH-1:1]};
        end else if (ddif[WIDTH]) begin
            hi_n = dsh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
        end else begin
            hi_n = ddif[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            hi     <= '0;
            lo     <= '0;
            b      <= '0;
            result <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    zero <= (op1 == op2);
                    if (multi) begin
                        state <= CALC;
                        cnt   <= CW'(WIDTH - 1);
                        op_r  <= alu_op;
                        hi    <= '0;
                        lo    <= op1;
                        b     <= op2;
                        ovf   <= 1'b0;
                    end else begin
                        state  <= DONE;
                        result <= alu_res;
                        ovf    <= alu_ovf;
                    end
                end
                CALC: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // divide by zero falls out naturally: all quotient bits 1, remainder = op1
                        result <= (op_r == 4'd12 || op_r == 4'd14) ? hi_n : lo_n;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results go into a scoreboard queue when an op
// is driven and are popped when the DUT raises out_valid.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2, result;
    logic        zero, ovf, busy;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op1(op1), .op2(op2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_res"}, 64'(result), 64'(e.res));
        chk({tag, "_zero"}, 64'(zero), 64'(e.z));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e.o));
    endtask

    // One op from IDLE; checks acceptance latency, result, then handshakes it away.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] bb, input logic [31:0] er, input logic ez,
                         input logic eo, input int lat);
        int n = 0;
        int rdy_bad = 0;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; alu_op = op; op1 = a; op2 = bb; out_ready = 1'b0;
        sb.push_back('{er, ez, eo});
        @(negedge clk);
        // scramble inputs after acceptance; operands must already be captured
        in_valid = 1'b0; op1 = $urandom; op2 = $urandom; alu_op = 4'($urandom);
        while (!out_valid && n < 200) begin
            if (in_ready || !busy) rdy_bad++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_ready_low"}, 64'(rdy_bad), 64'd0);
        pop_cmp(tag);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_hs"}, {62'd0, out_valid, in_ready}, 64'b01);
        out_ready = 1'b0;
    endtask

    initial begin
        int acc[$];
        int bad;
        logic [31:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; op1 = '0; op2 = '0;
        #1;
        chk("rst_outs", {58'd0, out_valid, busy, zero, ovf, in_ready, 1'b0}, 64'b000010);
        chk("rst_result", 64'(result), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // back-to-back adds with out_ready held: accepts every second cycle
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; alu_op = 4'd0; op1 = 32'h7FFF_FFFF; op2 = 32'h1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) pop_cmp("b2b");
            if (in_ready) begin
                acc.push_back(i);
                sb.push_back('{32'h8000_0000, 1'b0, 1'b1});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (out_valid) pop_cmp("b2b_last");
        @(negedge clk);
        chk("b2b_gap", 64'(acc[1] - acc[0]), 64'd2);
        chk("b2b_cnt", 64'(acc.size()), 64'd3);
        sb.delete();
        out_ready = 1'b0;

        do_op("add",   4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 0);
        do_op("sub",   4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, 0);
        do_op("subeq", 4'd1,  32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 0);
        do_op("add7",  4'd7,  32'h3,         32'h3,         32'h6,         1'b1, 1'b0, 0);
        do_op("or",    4'd2,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 0);
        do_op("xor",   4'd3,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1'b0, 0);
        do_op("and",   4'd4,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 0);
        do_op("slt",   4'd6,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 0);
        do_op("sltu",  4'd5,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 0);
        do_op("sll",   4'd8,  32'h1,         32'hFF,        32'h8000_0000, 1'b0, 1'b0, 0);
        do_op("srl",   4'd9,  32'h8000_0000, 32'h21,        32'h4000_0000, 1'b0, 1'b0, 0);
        do_op("sra",   4'd10, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1'b0, 0);
        do_op("nor",   4'd15, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00, 1'b0, 1'b0, 0);
        do_op("mul",   4'd11, 32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0, 1'b0, 32);
        do_op("mulhu", 4'd12, 32'h1234_5678, 32'h10,        32'h1,         1'b0, 1'b0, 32);
        do_op("mulff", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0, 32);
        do_op("mhuff", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 32);
        do_op("divu",  4'd13, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 32);
        do_op("remu",  4'd14, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 32);
        do_op("div0",  4'd13, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 32);
        do_op("rem0",  4'd14, 32'd5,         32'd0,         32'd5,         1'b0, 1'b0, 32);
        do_op("divbig",4'd13, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 32);
        do_op("rembig",4'd14, 32'hFFFF_FFFF, 32'd3,         32'd0,         1'b0, 1'b0, 32);

        // consumer stalls for 10 cycles while a second op waits on in_valid
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd3; op1 = 32'hA5A5_A5A5; op2 = 32'hFFFF_0000; out_ready = 1'b0;
        sb.push_back('{32'h5A5A_A5A5, 1'b0, 1'b0});
        @(negedge clk);
        alu_op = 4'd0; op1 = 32'd10; op2 = 32'd20;
        chk("stall_ov", 64'(out_valid), 64'd1);
        held = result;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || in_ready || result !== held) bad++;
            @(negedge clk);
        end
        chk("stall_stable", 64'(bad), 64'd0);
        pop_cmp("stall");
        out_ready = 1'b1;
        sb.push_back('{32'd30, 1'b0, 1'b0});
        @(negedge clk);
        chk("stall_hs", {62'd0, out_valid, in_ready}, 64'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_next_ov", 64'(out_valid), 64'd1);
        pop_cmp("stall_next");
        @(negedge clk);
        out_ready = 1'b0;

        // reset in the middle of a divide
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd13; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {59'd0, out_valid, busy, zero, ovf, in_ready}, 64'b00001);
        chk("mid_rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        chk("no_stale", 64'(bad), 64'd0);
        do_op("post_rst", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the datapath ALU. It adds shifts and iterative multiply/divide, and puts a valid/ready handshake on both the operand side and the result side. The block sits in the execute stage. The stall logic must hold the pipeline while `in_ready` or `out_valid` is low. Op codes 0–7 keep the existing ALU encoding, so the decoder needs no changes for those ops.

## Interface
- `WIDTH`, default 32, operand/result width in bits; must be ≥ 4 and a power of two
- `SHW`, default `$clog2(WIDTH)`, number of shift-amount bits taken from `op2`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands and op code are valid
- `in_ready`  out  1  block can accept; equals (state == IDLE)
- `alu_op`  in  4  operation select
- `op1`, `op2`  in  WIDTH  operands
- `out_valid`  out  1  `result`/`zero`/`ovf` are valid
- `out_ready`  in  1  consumer takes the result
- `result`  out  WIDTH  registered result
- `zero`  out  1  registered (op1 == op2) of the accepted operands
- `ovf`  out  1  registered signed overflow; valid for add/sub only, 0 for every other op
- `busy`  out  1  state != IDLE

## Operation
- Op codes, all unsigned unless stated otherwise:
  - 0 add
  - 1 sub
  - 2 or
  - 3 xor
  - 4 and
  - 5 sltu
  - 6 slt (signed)
  - 7 add, kept as an alias of 0
  - 8 sll
  - 9 srl
  - 10 sra
  - 11 mul, low WIDTH bits
  - 12 mulhu, high WIDTH bits
  - 13 divu
  - 14 remu
  - 15 nor
- Shifts use `op2[SHW-1:0]`; the upper bits of `op2` are ignored.
- slt/sltu write 1 or 0, zero-extended to WIDTH.
- mul/mulhu: radix-2 shift-add over a 2·WIDTH product register, one multiplier bit per cycle.
- divu/remu: restoring division, one quotient bit per cycle.
- Divide by zero: divu returns all-ones and remu returns `op1`. Still takes the full WIDTH cycles, with no special-case shortcut.
- Operands are captured on acceptance. Input changes after that have no effect.
- States:
  - IDLE: `in_ready` = 1. On accept, single-cycle ops (0–10, 15) go to DONE; ops 11–14 go to CALC with cnt = WIDTH−1.
  - CALC: processes one bit per cycle and decrements cnt. When cnt == 0 it writes `result` and goes to DONE.
  - DONE: `out_valid` = 1. Goes to IDLE when `out_ready` = 1.

## Timing
- Accept = `in_valid` & `in_ready` at a rising edge; call that edge T.
- Single-cycle ops: `result`, `zero` and `ovf` are registered at T, and `out_valid` is high from T.
- Ops 11–14: `out_valid` rises at edge T+WIDTH (T+32 by default).
- `result`, `zero` and `ovf` stay stable while `out_valid` is high, until the handshake edge.
- Handshake edge is `out_valid` & `out_ready`. `out_valid` falls and `in_ready` rises at that edge.
- Next accept is no earlier than the edge after the handshake, so single-cycle throughput is one op per 2 cycles.
- There is no accept while `out_valid` = 1. A held `in_valid` is not dropped; it is taken once IDLE is reached.
- `out_ready` held high in DONE: handshake happens on the first DONE cycle.
- Reset (`rst_n` low, at any time, including mid-CALC):
  - state = IDLE
  - `out_valid` = `busy` = 0
  - `result` = 0, `zero` = 0, `ovf` = 0
  - cnt and product/quotient registers = 0
  - `in_ready` = 1 while in reset
  - any in-flight op is discarded and produces no output.
- Overflow: add → (a[W−1] == b[W−1]) & (s[W−1] != a[W−1]); sub → (a[W−1] != b[W−1]) & (s[W−1] != a[W−1]).

## Test plan
- add 0x7FFFFFFF + 1, `out_ready` = 1 → `out_valid` at T, `result` = 0x80000000, `ovf` = 1, `zero` = 0. Back-to-back `in_valid` → second accept exactly 2 cycles later.
- slt 0xFFFFFFFF, 1 → 1; sltu same operands → 0; sra 0x80000000 by `op2` = 0x24 (amount 4) → 0xF8000000.
- mul 0x12345678 × 0x10 → `out_valid` at T+32, `result` = 0x23456780. mulhu same operands → 0x00000001. `in_ready` = 0 throughout.
- divu 100 / 7 → 14; remu → 2. divu 5 / 0 → 0xFFFFFFFF; remu 5 / 0 → 5. Both at T+32.
- Hold `out_ready` = 0 for 10 cycles after `out_valid` → `result` stable; a new `in_valid` is not accepted until the cycle after the handshake.
- Assert `rst_n` = 0 at T+10 of a divu → all outputs 0 immediately. After release, no stale `out_valid`, and the next add completes normally.
